// File: rtl/construtor_caminho_pkg.sv
// rtl/construtor_caminho_pkg.sv - shared types and defaults for the path-construction stage
package construtor_caminho_pkg;

    localparam int CC_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        CC_OCIOSO = 3'd0,
        CC_LER    = 3'd1,
        CC_ESPERA = 3'd2,
        CC_ENVIAR = 3'd3,
        CC_ERRO   = 3'd4
    } cc_estado_t;

endpackage

// File: rtl/construtor_caminho_pilha.sv
// rtl/construtor_caminho_pilha.sv - path LIFO with push/pop/clear, registered count, combinational top
module construtor_caminho_pilha #(
    parameter int ADDR_WIDTH  = 6,
    parameter int MAX_CAMINHO = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int IW = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
    localparam logic [CW-1:0] CNT_UM = CW'(1);

    logic [ADDR_WIDTH-1:0] mem [MAX_CAMINHO];

    // Storage carries no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[IW'(count)] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_UM;
        end else if (pop && !push) begin
            count <= count - CNT_UM;
        end
    end

    assign top_data = mem[IW'(count - CNT_UM)];

endmodule

// File: rtl/construtor_caminho.sv
// rtl/construtor_caminho.sv - walks the predecessor chain destino->fonte and streams the path fonte-first
module construtor_caminho
    import construtor_caminho_pkg::*;
#(
    parameter int ADDR_WIDTH  = CC_ADDR_WIDTH,
    parameter int MAX_CAMINHO = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cme_construir_caminho_in,
    input  logic [ADDR_WIDTH-1:0] top_fonte_in,
    input  logic [ADDR_WIDTH-1:0] top_destino_in,
    output logic                  cc_anterior_rd_en_out,
    output logic [ADDR_WIDTH-1:0] cc_anterior_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0] gma_anterior_rd_data_in,
    output logic                  cc_caminho_valid_out,
    output logic [ADDR_WIDTH-1:0] cc_caminho_addr_out,
    input  logic                  lido_in,
    output logic                  cc_caminho_pronto_out,
    output logic                  cc_ocupado_out,
    output logic                  cc_erro_out
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CAMINHO);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    cc_estado_t            estado;
    logic [ADDR_WIDTH-1:0] fonte;
    logic [ADDR_WIDTH-1:0] atual;

    logic                  push;
    logic                  pop;
    logic                  clear;
    logic [ADDR_WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] topo;
    logic [CW-1:0]         count;
    logic                  cheia;
    logic                  aceite;

    assign cheia  = (count == CNT_MAX);
    assign aceite = (estado == CC_ENVIAR) && cc_caminho_valid_out && lido_in;

    construtor_caminho_pilha #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MAX_CAMINHO (MAX_CAMINHO)
    ) u_pilha (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_data),
        .top_data  (topo),
        .count     (count)
    );

    // The predecessor memory answers while rd_en is high, so ESPERA consumes the data directly.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        push_data = '0;
        case (estado)
            CC_OCIOSO: begin
                push      = cme_construir_caminho_in;
                push_data = top_destino_in;
            end
            CC_ESPERA: begin
                push      = !cheia;
                push_data = gma_anterior_rd_data_in;
            end
            CC_ENVIAR: pop   = aceite;
            CC_ERRO:   clear = 1'b1;
            default: ;
        endcase
    end

    assign cc_caminho_addr_out = cc_caminho_valid_out ? topo : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado                  <= CC_OCIOSO;
            fonte                   <= '0;
            atual                   <= '0;
            cc_anterior_rd_en_out   <= 1'b0;
            cc_anterior_rd_addr_out <= '0;
            cc_caminho_valid_out    <= 1'b0;
            cc_caminho_pronto_out   <= 1'b0;
            cc_ocupado_out          <= 1'b0;
            cc_erro_out             <= 1'b0;
        end else begin
            cc_anterior_rd_en_out   <= 1'b0;
            cc_anterior_rd_addr_out <= '0;
            cc_caminho_pronto_out   <= 1'b0;
            case (estado)
                CC_OCIOSO: begin
                    if (cme_construir_caminho_in) begin
                        fonte          <= top_fonte_in;
                        atual          <= top_destino_in;
                        cc_erro_out    <= 1'b0;
                        cc_ocupado_out <= 1'b1;
                        estado         <= CC_LER;
                    end
                end
                CC_LER: begin
                    if (atual == fonte) begin
                        estado <= CC_ENVIAR;
                    end else begin
                        cc_anterior_rd_en_out   <= 1'b1;
                        cc_anterior_rd_addr_out <= atual;
                        estado                  <= CC_ESPERA;
                    end
                end
                CC_ESPERA: begin
                    if (cheia) begin
                        cc_erro_out <= 1'b1;
                        estado      <= CC_ERRO;
                    end else begin
                        atual  <= gma_anterior_rd_data_in;
                        estado <= CC_LER;
                    end
                end
                CC_ENVIAR: begin
                    if (!cc_caminho_valid_out) begin
                        cc_caminho_valid_out <= 1'b1;
                    end else if (lido_in && (count == CNT_UM)) begin
                        cc_caminho_valid_out  <= 1'b0;
                        cc_caminho_pronto_out <= 1'b1;
                        cc_ocupado_out        <= 1'b0;
                        estado                <= CC_OCIOSO;
                    end
                end
                CC_ERRO: begin
                    cc_ocupado_out <= 1'b0;
                    estado         <= CC_OCIOSO;
                end
                default: begin
                    cc_ocupado_out <= 1'b0;
                    estado         <= CC_OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_construtor_caminho.sv
// tb/tb_construtor_caminho.sv - randomized self-checking bench for construtor_caminho
module tb_construtor_caminho;

    localparam int AW   = 6;
    localparam int MAXC = 8;

    typedef logic [AW-1:0] node_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    node_t       top_fonte = '0;
    node_t       top_destino = '0;
    logic        rd_en;
    node_t       rd_addr;
    node_t       gma;
    logic        valid;
    node_t       addr;
    logic        lido = 1'b0;
    logic        pronto;
    logic        ocupado;
    logic        erro;

    node_t mem [64];
    assign gma = mem[rd_addr];

    construtor_caminho #(.ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .cme_construir_caminho_in (start),
        .top_fonte_in             (top_fonte),
        .top_destino_in           (top_destino),
        .cc_anterior_rd_en_out    (rd_en),
        .cc_anterior_rd_addr_out  (rd_addr),
        .gma_anterior_rd_data_in  (gma),
        .cc_caminho_valid_out     (valid),
        .cc_caminho_addr_out      (addr),
        .lido_in                  (lido),
        .cc_caminho_pronto_out    (pronto),
        .cc_ocupado_out           (ocupado),
        .cc_erro_out              (erro)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail = 0;

    node_t got_nodes[$];
    node_t got_reads[$];
    node_t exp_nodes[$];
    node_t exp_reads[$];
    bit    exp_err;
    int    first_valid, pronto_k, last_acc_k, viol, n_acc;
    bit    erro_seen, valid_ever, timed_out, erro_at0, ocup_at_pronto;
    logic [6:0] abort_outs;

    function automatic bit q_eq(input node_t a[$], input node_t b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q2s(input node_t q[$]);
        string s = "{";
        foreach (q[i]) s = {s, $sformatf("%0d%s", q[i], (i == q.size() - 1) ? "" : ",")};
        return {s, "}"};
    endfunction

    // Reference: follow predecessors from destino until fonte, bounded by LIFO depth.
    task automatic model(input node_t f, input node_t d);
        node_t path[$];
        node_t a;
        exp_nodes.delete();
        exp_reads.delete();
        exp_err = 1'b0;
        a = d;
        path.push_back(d);
        while (a != f) begin
            exp_reads.push_back(a);
            if (path.size() == MAXC) begin
                exp_err = 1'b1;
                break;
            end
            a = mem[a];
            path.push_back(a);
        end
        if (!exp_err) for (int i = path.size() - 1; i >= 0; i--) exp_nodes.push_back(path[i]);
    endtask

    // mode 0: lido always high; 1: low 10 cycles after valid then toggling; 2: random
    task automatic run_path(input node_t f, input node_t d, input int mode, input bit interfere,
                            input int abort_after);
        bit    prev_valid = 1'b0;
        bit    prev_lido = 1'b0;
        node_t prev_addr = '0;
        got_nodes.delete();
        got_reads.delete();
        first_valid = -1; pronto_k = -1; last_acc_k = -1; viol = 0; n_acc = 0;
        erro_seen = 0; valid_ever = 0; timed_out = 1; erro_at0 = 0; ocup_at_pronto = 1;
        abort_outs = '1;
        @(negedge clk);
        top_fonte = f; top_destino = d; start = 1'b1; lido = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            if (abort_after > 0 && n_acc == abort_after) begin
                lido = 1'b0; start = 1'b0; rst_n = 1'b0;
                #1;
                abort_outs = {valid, |addr, rd_en, |rd_addr, pronto, ocupado, erro};
                timed_out = 0;
                break;
            end
            if (k == 0) erro_at0 = erro;
            if (rd_en) got_reads.push_back(rd_addr);
            if (valid) begin
                valid_ever = 1;
                if (first_valid < 0) first_valid = k;
            end
            if (prev_valid && !prev_lido && (!valid || addr !== prev_addr)) viol++;
            if (pronto) begin
                pronto_k = k; ocup_at_pronto = ocupado; timed_out = 0;
                break;
            end
            if (erro && !ocupado) begin
                erro_seen = 1; timed_out = 0;
                break;
            end
            case (mode)
                0: lido = 1'b1;
                1: lido = (first_valid < 0) ? 1'b1 : ((k - first_valid >= 10) ? k[0] : 1'b0);
                default: lido = 1'($urandom_range(0, 1));
            endcase
            start = interfere && (k == 0 || k == first_valid);
            if (start) begin
                top_fonte = ~f; top_destino = ~d;
            end
            if (valid && lido) begin
                got_nodes.push_back(addr); last_acc_k = k; n_acc++;
            end
            prev_valid = valid; prev_lido = lido; prev_addr = addr;
            @(negedge clk);
        end
        start = 1'b0;
        lido = 1'b0;
    endtask

    task automatic set_chain();
        foreach (mem[i]) mem[i] = node_t'($urandom_range(0, 63));
        mem[9] = 5; mem[5] = 2; mem[2] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valid, addr, rd_en, rd_addr, pronto, ocupado, erro} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b a=%0d rd=%b ra=%0d p=%b o=%b e=%b, need all 0",
                     valid, addr, rd_en, rd_addr, pronto, ocupado, erro);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_self_path();
        model(0, 0);
        run_path(0, 0, 0, 0, 0);
        n_checks++;
        if (timed_out || got_reads.size() != 0 || first_valid != 2) begin
            n_fail++;
            $display("FAIL self_timing: timeout=%0b reads=%0d first_valid=%0d, need 0 reads valid at 2",
                     timed_out, got_reads.size(), first_valid);
        end
        n_checks++;
        if (!q_eq(got_nodes, exp_nodes)) begin
            n_fail++;
            $display("FAIL self_nodes: got %s need %s", q2s(got_nodes), q2s(exp_nodes));
        end
        n_checks++;
        if (pronto_k != last_acc_k + 1 || ocup_at_pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL self_pronto: pronto at %0d ocupado=%b, need %0d and 0",
                     pronto_k, ocup_at_pronto, last_acc_k + 1);
        end
    endtask

    task automatic test_chain();
        set_chain();
        model(0, 9);
        run_path(0, 9, 0, 0, 0);
        n_checks++;
        if (!q_eq(got_reads, exp_reads)) begin
            n_fail++;
            $display("FAIL chain_reads: got %s need %s", q2s(got_reads), q2s(exp_reads));
        end
        n_checks++;
        if (!q_eq(got_nodes, exp_nodes)) begin
            n_fail++;
            $display("FAIL chain_nodes: got %s need %s", q2s(got_nodes), q2s(exp_nodes));
        end
        n_checks++;
        if (first_valid != 8 || last_acc_k - first_valid != 3 || pronto_k != last_acc_k + 1) begin
            n_fail++;
            $display("FAIL chain_timing: valid@%0d last@%0d pronto@%0d, need 8 11 12",
                     first_valid, last_acc_k, pronto_k);
        end
    endtask

    task automatic test_lido_stall();
        set_chain();
        model(0, 9);
        run_path(0, 9, 1, 0, 0);
        n_checks++;
        if (viol != 0 || timed_out) begin
            n_fail++;
            $display("FAIL stall_stable: %0d changes while stalled timeout=%0b, need 0 and 0", viol, timed_out);
        end
        n_checks++;
        if (!q_eq(got_nodes, exp_nodes)) begin
            n_fail++;
            $display("FAIL stall_nodes: got %s need %s", q2s(got_nodes), q2s(exp_nodes));
        end
    endtask

    task automatic test_ignored_start();
        set_chain();
        model(0, 9);
        run_path(0, 9, 0, 1, 0);
        n_checks++;
        if (!q_eq(got_nodes, exp_nodes) || !q_eq(got_reads, exp_reads)) begin
            n_fail++;
            $display("FAIL busy_start: nodes %s reads %s, need %s %s",
                     q2s(got_nodes), q2s(got_reads), q2s(exp_nodes), q2s(exp_reads));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_idle: ocupado=%b, need 0", ocupado);
        end
    endtask

    task automatic test_overflow();
        foreach (mem[i]) mem[i] = node_t'($urandom_range(0, 63));
        mem[3] = 4; mem[4] = 3;
        model(0, 3);
        run_path(0, 3, 0, 0, 0);
        n_checks++;
        if (!erro_seen || valid_ever || !exp_err) begin
            n_fail++;
            $display("FAIL overflow_erro: erro=%b valid_ever=%b, need 1 and 0", erro_seen, valid_ever);
        end
        n_checks++;
        if (!q_eq(got_reads, exp_reads)) begin
            n_fail++;
            $display("FAIL overflow_reads: got %s need %s", q2s(got_reads), q2s(exp_reads));
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (erro !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: erro=%b, need 1", erro);
        end
        model(0, 0);
        run_path(0, 0, 0, 0, 0);
        n_checks++;
        if (erro_at0 !== 1'b0 || !q_eq(got_nodes, exp_nodes)) begin
            n_fail++;
            $display("FAIL overflow_clear: erro=%b nodes %s, need 0 %s", erro_at0, q2s(got_nodes), q2s(exp_nodes));
        end
    endtask

    task automatic test_reset_mid();
        set_chain();
        run_path(0, 9, 0, 0, 2);
        n_checks++;
        if (abort_outs !== 7'b0 || n_acc != 2) begin
            n_fail++;
            $display("FAIL reset_mid: outs=%b accepts=%0d, need 0000000 and 2", abort_outs, n_acc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(0, 9);
        run_path(0, 9, 0, 0, 0);
        n_checks++;
        if (!q_eq(got_nodes, exp_nodes) || !q_eq(got_reads, exp_reads)) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: nodes %s reads %s, need %s %s",
                     q2s(got_nodes), q2s(got_reads), q2s(exp_nodes), q2s(exp_reads));
        end
    endtask

    task automatic test_random();
        node_t lst[$];
        node_t f, d, c;
        int    n;
        for (int it = 0; it < 24; it++) begin
            foreach (mem[i]) mem[i] = node_t'($urandom_range(0, 63));
            if (it % 3 != 0) begin
                n = $urandom_range(1, MAXC);
                lst.delete();
                while (lst.size() < n) begin
                    c = node_t'($urandom_range(0, 63));
                    if (!(c inside {lst})) lst.push_back(c);
                end
                for (int i = 1; i < n; i++) mem[lst[i]] = lst[i-1];
                f = lst[0];
                d = lst[n-1];
            end else begin
                f = node_t'($urandom_range(0, 63));
                d = node_t'($urandom_range(0, 63));
            end
            model(f, d);
            run_path(f, d, 2, 0, 0);
            n_checks++;
            if (timed_out || erro_seen != exp_err || !q_eq(got_reads, exp_reads)) begin
                n_fail++;
                $display("FAIL rand%0d_reads: timeout=%0b erro=%b reads %s, need erro=%b reads %s",
                         it, timed_out, erro_seen, q2s(got_reads), exp_err, q2s(exp_reads));
            end
            n_checks++;
            if (!q_eq(got_nodes, exp_nodes) || viol != 0 ||
                (!exp_err && first_valid != 2 * exp_nodes.size())) begin
                n_fail++;
                $display("FAIL rand%0d_nodes: got %s valid@%0d unstable=%0d, need %s valid@%0d",
                         it, q2s(got_nodes), first_valid, viol, q2s(exp_nodes), 2 * exp_nodes.size());
            end
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = '0;
        test_reset();
        test_self_path();
        test_chain();
        test_lido_stall();
        test_ignored_start();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
